// File: rtl/cloth_step_scheduler.sv
// cloth_step_scheduler: per-frame sequencer, one Verlet cycle then NUM_ITERS constraint passes over a shared solver
// Ports: clk, reset (async, active-high); frame_tick, pause (frame requests);
//   verlet_state, fix_en (one-hot, segment j writes node j+1) to the Node array;
//   solve_req/solve_seg/solve_ack handshake with the constraint solver;
//   busy, frame_done, iter_cnt, overrun (sticky) status.
// Build option ALT_SWEEP_EN: odd passes sweep segments in reverse order.
module cloth_step_scheduler #(
  parameter int NUM_NODES = 8,
  parameter int IDX_W = 3,
  parameter int NUM_ITERS = 4,
  parameter int ITER_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 pause,
  output logic                 verlet_state,
  output logic [NUM_NODES-1:0] fix_en,
  output logic                 solve_req,
  output logic [IDX_W-1:0]     solve_seg,
  input  logic                 solve_ack,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ITER_W-1:0]    iter_cnt,
  output logic                 overrun
);
  typedef enum logic [2:0] {IDLE, VERLET, REQ, WRITE, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_NODES - 2);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITERS - 1);
`ifdef ALT_SWEEP_EN
  localparam logic ALT = 1'b1;
`else
  localparam logic ALT = 1'b0;
`endif
  state_t state, state_n;
  logic [IDX_W-1:0] seg_n;
  logic [ITER_W-1:0] iter_n;
  logic rev, at_end;
  // solve_seg doubles as the segment register; it only moves when leaving WRITE
  assign rev = ALT & iter_cnt[0];
  assign at_end = solve_seg == (rev ? '0 : LAST_SEG);
  always_comb begin
    state_n = state;
    seg_n = solve_seg;
    iter_n = iter_cnt;
    case (state)
      IDLE: state_n = frame_tick && !pause ? VERLET : IDLE;
      VERLET: begin
        state_n = REQ;
        seg_n = '0;
      end
      REQ: state_n = solve_ack ? WRITE : REQ;
      WRITE: begin
        state_n = at_end && iter_cnt == LAST_ITER ? DONE : REQ;
        if (!at_end) seg_n = rev ? solve_seg - 1'b1 : solve_seg + 1'b1;
        else if (iter_cnt != LAST_ITER) begin
          iter_n = iter_cnt + 1'b1;
          // the pass about to start is odd when the current one is even
          seg_n = ALT && !iter_cnt[0] ? LAST_SEG : '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        seg_n = '0;
        iter_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every one leaves a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      verlet_state <= 1'b0;
      fix_en <= '0;
      solve_req <= 1'b0;
      solve_seg <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      iter_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      verlet_state <= state_n == VERLET;
      fix_en <= state_n == WRITE ? NUM_NODES'(1) << (seg_n + 1'b1) : '0;
      solve_req <= state_n == REQ;
      solve_seg <= seg_n;
      busy <= state_n != IDLE;
      frame_done <= state_n == DONE;
      iter_cnt <= iter_n;
      overrun <= overrun | (frame_tick && state != IDLE);
    end
  end
endmodule

// File: tb/tb_cloth_step_scheduler.sv
// tb_cloth_step_scheduler: frame-level checks of cloth_step_scheduler against a pass/segment model
module tb_cloth_step_scheduler;
  localparam int NN = 8;
  localparam int NI = 4;
  localparam int IW = 3;
  localparam int TW = 3;
  logic clk = 1'b0;
  logic reset, frame_tick, pause, solve_ack;
  logic verlet_state, solve_req, busy, frame_done, overrun;
  logic [NN-1:0] fix_en;
  logic [IW-1:0] solve_seg;
  logic [TW-1:0] iter_cnt;
  int tests = 0;
  int fails = 0;
  typedef struct {
    int dly;
    int tick2;
    int pause_at;
    int ovr;
    int done;
  } row_t;
  row_t rows[7];
  cloth_step_scheduler #(.NUM_NODES(NN), .IDX_W(IW), .NUM_ITERS(NI), .ITER_W(TW)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .verlet_state(verlet_state), .fix_en(fix_en), .solve_req(solve_req),
    .solve_seg(solve_seg), .solve_ack(solve_ack), .busy(busy),
    .frame_done(frame_done), .iter_cnt(iter_cnt), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int outs_or();
    return int'({verlet_state, |fix_en, solve_req, |solve_seg, busy, frame_done, |iter_cnt, overrun});
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    pause = 1'b0;
    solve_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  // one frame: tick in cycle 0, solver answers d cycles after each request,
  // expected node order and frame length come from the pass/segment rules
  task automatic run_row(input int idx, input row_t r);
    int q[$];
    int qi[$];
    int c, d, wait_n, mdone, done_at, ndone, ord_bad, inv_bad, seg_bad, verlet_at, idle_bad, n;
    logic prev_req;
    logic [IW-1:0] held;
    for (int it = 0; it < NI; it++)
      for (int j = 0; j < NN - 1; j++) begin
`ifdef ALT_SWEEP_EN
        q.push_back(it % 2 ? NN - 1 - j : j + 1);
`else
        q.push_back(j + 1);
`endif
        qi.push_back(it);
      end
    mdone = 2;
    done_at = -1;
    verlet_at = -1;
    ndone = 0; ord_bad = 0; inv_bad = 0; seg_bad = 0; idle_bad = 0;
    wait_n = 0;
    prev_req = 1'b0;
    held = '0;
    do_reset();
    @(negedge clk);
    frame_tick = 1'b1;
    c = 0;
    while (c < 2000) begin
      @(negedge clk);
      c++;
      frame_tick = c == r.tick2;
      pause = r.pause_at > 0 && c >= r.pause_at;
      if (verlet_state) begin
        if (verlet_at < 0) verlet_at = c;
        else inv_bad++;
      end
      if (fix_en != '0) begin
        n = q.size() > 0 ? q.pop_front() : 0;
        if (qi.size() > 0) void'(qi.pop_front());
        if (fix_en != (NN'(1) << n)) ord_bad++;
      end
      if (((fix_en & (fix_en - 1'b1)) != '0) || fix_en[0] || (verlet_state && fix_en != '0)) inv_bad++;
      if (solve_req) begin
        if (!prev_req) begin
          d = r.dly >= 0 ? r.dly : int'($urandom_range(0, 4));
          wait_n = d;
          mdone += d + 2;
          held = solve_seg;
        end else if (solve_seg != held) seg_bad++;
        if (q.size() == 0 || int'(solve_seg) != q[0] - 1 || int'(iter_cnt) != qi[0]) seg_bad++;
        solve_ack = wait_n <= 0;
        wait_n--;
      end else solve_ack = 1'($urandom_range(0, 1));
      prev_req = solve_req;
      if (frame_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (!busy) break;
    end
    n = r.done >= 0 ? r.done : mdone;
    check($sformatf("r%0d_verlet_at", idx), verlet_at, 1);
    check($sformatf("r%0d_done_at", idx), done_at, n);
    check($sformatf("r%0d_idle_at", idx), c, n + 1);
    check($sformatf("r%0d_done_count", idx), ndone, 1);
    check($sformatf("r%0d_fix_left", idx), q.size(), 0);
    check($sformatf("r%0d_fix_order", idx), ord_bad, 0);
    check($sformatf("r%0d_invariants", idx), inv_bad, 0);
    check($sformatf("r%0d_seg_iter", idx), seg_bad, 0);
    check($sformatf("r%0d_overrun", idx), int'(overrun), r.ovr);
    repeat (4) begin
      @(negedge clk);
      if (busy || verlet_state || frame_done) idle_bad++;
    end
    check($sformatf("r%0d_stays_idle", idx), idle_bad, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, bad;
    rows[0] = '{0, 0, 0, 0, 58};
    rows[1] = '{3, 0, 0, 0, 142};
    rows[2] = '{0, 0, 20, 0, 58};
    rows[3] = '{0, 10, 0, 1, 58};
    rows[4] = '{1, 86, 0, 1, 86};
    rows[5] = '{-1, 0, 0, 0, -1};
    rows[6] = '{-1, 30, 40, 1, -1};
    do_reset();
    check("reset_state", outs_or(), 0);
    for (int i = 0; i < 7; i++) run_row(i, rows[i]);
    do_reset();
    pause = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bad = 0;
    repeat (5) begin
      if (busy || verlet_state) bad++;
      @(negedge clk);
    end
    check("pause_idle_start", bad, 0);
    check("pause_idle_overrun", int'(overrun), 0);
    pause = 1'b0;
    do_reset();
    frame_tick = 1'b1;
    solve_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      frame_tick = 1'b0;
      n++;
    end while (!(iter_cnt == 1 && solve_req) && n < 200);
    solve_ack = 1'b0;
    check("reach_iter1", int'(iter_cnt), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", outs_or(), 0);
    @(negedge clk);
    check("reset_held", outs_or(), 0);
    reset = 1'b0;
    frame_tick = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      frame_tick = 1'b0;
      n++;
    end while (!solve_req && n < 20);
    check("restart_latency", n, 2);
    check("restart_seg", int'(solve_seg), 0);
    check("restart_iter", int'(iter_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
